// File: rtl/gpio_bank.sv
`default_nettype none
// ============================================================================
//  Module     : gpio_bank
//  Description: Multi-channel GPIO bank with OUT/IN/EDGE/MASK registers per
//               channel, synchronised inputs and a masked rising-edge IRQ.
//               Edge/IRQ logic is built only when GPIO_BANK_EDGE_IRQ_EN is
//               defined.
//  Revision   : 1.0 - initial release
// ============================================================================
module gpio_bank #(
    parameter int WIDTH       = 32,
    parameter int NCH         = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [3:0]             A,
    input  logic                   WE,
    input  logic [WIDTH-1:0]       WD,
    input  logic [NCH*WIDTH-1:0]   gpI,
    output logic [NCH*WIDTH-1:0]   gpO,
    output logic [WIDTH-1:0]       gpio_data_out,
    output logic                   irq
);

    localparam logic [1:0] c_REG_OUT  = 2'd0;
    localparam logic [1:0] c_REG_IN   = 2'd1;
    localparam logic [1:0] c_REG_EDGE = 2'd2;
    localparam logic [1:0] c_REG_MASK = 2'd3;
    localparam logic [2:0] c_NCH      = 3'(NCH);

    logic [1:0]                        w_ch;
    logic                              w_ch_ok;
    logic                              w_wr;
    logic [NCH*WIDTH-1:0]              r_out;
    logic [SYNC_STAGES-1:0][NCH*WIDTH-1:0] r_sync;
    logic [NCH*WIDTH-1:0]              w_in;
    logic [NCH*WIDTH-1:0]              w_edge_v;
    logic [NCH*WIDTH-1:0]              w_mask_v;

    assign w_ch    = A[3:2];
    assign w_ch_ok = ({1'b0, w_ch} < c_NCH);
    assign w_wr    = WE && w_ch_ok;

    // Input synchroniser; the last stage is the architectural IN value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= gpI;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    assign w_in = r_sync[SYNC_STAGES-1];

    generate
        for (genvar c = 0; c < NCH; c++) begin : g_out
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_out[c*WIDTH +: WIDTH] <= '0;
                end else if (w_wr && (w_ch == 2'(c)) && (A[1:0] == c_REG_OUT)) begin
                    r_out[c*WIDTH +: WIDTH] <= WD;
                end
            end
        end
    endgenerate

    assign gpO = r_out;

`ifdef GPIO_BANK_EDGE_IRQ_EN
    logic [NCH*WIDTH-1:0] r_dly;
    logic [NCH*WIDTH-1:0] r_edge;
    logic [NCH*WIDTH-1:0] r_mask;
    logic [NCH*WIDTH-1:0] w_rise;
    logic [NCH*WIDTH-1:0] w_clr;
    logic                 r_irq;

    assign w_rise = w_in & ~r_dly;

    generate
        for (genvar c = 0; c < NCH; c++) begin : g_edge
            assign w_clr[c*WIDTH +: WIDTH] =
                (w_wr && (w_ch == 2'(c)) && (A[1:0] == c_REG_EDGE)) ? WD : '0;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_mask[c*WIDTH +: WIDTH] <= '0;
                end else if (w_wr && (w_ch == 2'(c)) && (A[1:0] == c_REG_MASK)) begin
                    r_mask[c*WIDTH +: WIDTH] <= WD;
                end
            end
        end
    endgenerate

    // Reset clears the whole chain, so the delay flop reloads from a zeroed
    // last stage on the first cycle and no edge can appear there.
    // Set is OR-ed after the clear so a coincident set wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dly  <= '0;
            r_edge <= '0;
            r_irq  <= 1'b0;
        end else begin
            r_dly  <= w_in;
            r_edge <= (r_edge & ~w_clr) | w_rise;
            r_irq  <= |(r_edge & r_mask);
        end
    end

    assign w_edge_v = r_edge;
    assign w_mask_v = r_mask;
    assign irq      = r_irq;
`else
    assign w_edge_v = '0;
    assign w_mask_v = '0;
    assign irq      = 1'b0;
`endif

    always_comb begin
        gpio_data_out = '0;
        for (int c = 0; c < NCH; c++) begin
            if (w_ch_ok && (w_ch == 2'(c))) begin
                case (A[1:0])
                    c_REG_OUT:  gpio_data_out = r_out[c*WIDTH +: WIDTH];
                    c_REG_IN:   gpio_data_out = w_in[c*WIDTH +: WIDTH];
                    c_REG_EDGE: gpio_data_out = w_edge_v[c*WIDTH +: WIDTH];
                    default:    gpio_data_out = w_mask_v[c*WIDTH +: WIDTH];
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gpio_bank.sv
`default_nettype none
// ============================================================================
//  Module     : tb_gpio_bank
//  Description: Self-checking bench for gpio_bank (directed table + random
//               stimulus against a reference model).
//  Revision   : 1.0 - initial release
// ============================================================================
module tb_gpio_bank;

    localparam int WIDTH = 32;
    localparam int NCH   = 2;
    localparam int SYNC  = 2;
`ifdef GPIO_BANK_EDGE_IRQ_EN
    localparam bit EIRQ = 1'b1;
`else
    localparam bit EIRQ = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [3:0]           A   = '0;
    logic                 WE  = 1'b0;
    logic [WIDTH-1:0]     WD  = '0;
    logic [NCH*WIDTH-1:0] gpI = '0;
    logic [NCH*WIDTH-1:0] gpO;
    logic [WIDTH-1:0]     gpio_data_out;
    logic                 irq;

    always #5 clk = ~clk;

    gpio_bank #(.WIDTH(WIDTH), .NCH(NCH), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst(rst), .A(A), .WE(WE), .WD(WD), .gpI(gpI),
        .gpO(gpO), .gpio_data_out(gpio_data_out), .irq(irq)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit          rst;
        logic [3:0]  a;
        bit          we;
        logic [31:0] wd;
        logic [63:0] pins;
        logic [3:0]  ra;
        logic [31:0] erd;
        bit          eirq;
        logic [63:0] egpo;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit r, logic [3:0] a, bit we, logic [31:0] wd, logic [63:0] pins,
                                logic [3:0] ra, logic [31:0] erd, bit eirq, logic [63:0] egpo);
        vec_t v;
        v.rst = r; v.a = a; v.we = we; v.wd = wd; v.pins = pins;
        v.ra = ra; v.erd = erd; v.eirq = eirq; v.egpo = egpo;
        return v;
    endfunction

    // ---------------- reference model ----------------
    logic [WIDTH-1:0] m_out  [NCH];
    logic [WIDTH-1:0] m_edge [NCH];
    logic [WIDTH-1:0] m_mask [NCH];
    bit               m_irq;
    logic [63:0]      pin_q[$];
    logic [63:0]      m_in, m_in_old;

    // IN is the pin value sampled SYNC edges ago (zero until enough edges since reset).
    function automatic logic [63:0] in_now();
        if (pin_q.size() >= SYNC) return pin_q[pin_q.size()-SYNC];
        return '0;
    endfunction

    task automatic model_step(input bit r, input logic [3:0] a, input bit we,
                              input logic [31:0] wd, input logic [63:0] pins);
        int   ch;
        bit   irq_n;
        logic [63:0] rise;
        if (r) begin
            for (int c = 0; c < NCH; c++) begin
                m_out[c] = '0; m_edge[c] = '0; m_mask[c] = '0;
            end
            m_irq = 1'b0; pin_q.delete(); m_in = '0; m_in_old = '0;
        end else begin
            ch    = int'(a[3:2]);
            irq_n = 1'b0;
            for (int c = 0; c < NCH; c++) irq_n |= |(m_edge[c] & m_mask[c]);
            rise = m_in & ~m_in_old;
            for (int c = 0; c < NCH; c++) begin
                logic [WIDTH-1:0] clr;
                clr = (we && ch == c && a[1:0] == 2'd2) ? wd : '0;
                m_edge[c] = (m_edge[c] & ~clr) | rise[c*WIDTH +: WIDTH];
            end
            if (we && ch < NCH) begin
                if (a[1:0] == 2'd0) m_out[ch] = wd;
                if (a[1:0] == 2'd3) m_mask[ch] = wd;
            end
            m_irq = irq_n;
            pin_q.push_back(pins);
            m_in_old = m_in;
            m_in     = in_now();
        end
    endtask

    function automatic logic [31:0] exp_read(logic [3:0] a);
        int ch;
        ch = int'(a[3:2]);
        if (ch >= NCH) return '0;
        case (a[1:0])
            2'd0:    return m_out[ch];
            2'd1:    return m_in[ch*WIDTH +: WIDTH];
            2'd2:    return EIRQ ? m_edge[ch] : '0;
            default: return EIRQ ? m_mask[ch] : '0;
        endcase
    endfunction

    function automatic logic [63:0] exp_gpo();
        logic [63:0] g;
        for (int c = 0; c < NCH; c++) g[c*WIDTH +: WIDTH] = m_out[c];
        return g;
    endfunction

    initial begin
        logic [63:0] g1, g2;
        logic [31:0] erd;
        g1 = 64'hDEADBEEF_00000000;
        g2 = 64'hDEADBEEF_00001234;

        tbl.push_back(mk(1, 4'h0, 0, 32'h0,        64'h0,  4'h0, 32'h0,        0, 64'h0));
        tbl.push_back(mk(0, 4'h4, 1, 32'hDEADBEEF, 64'h0,  4'h4, 32'hDEADBEEF, 0, g1));
        tbl.push_back(mk(0, 4'h3, 1, 32'h8,        64'h0,  4'h3, 32'h8,        0, g1));
        tbl.push_back(mk(0, 4'h0, 0, 32'h0,        64'h8,  4'h1, 32'h0,        0, g1));
        tbl.push_back(mk(0, 4'h0, 0, 32'h0,        64'h8,  4'h1, 32'h8,        0, g1));
        tbl.push_back(mk(0, 4'h0, 0, 32'h0,        64'h8,  4'h2, 32'h8,        0, g1));
        tbl.push_back(mk(0, 4'h0, 0, 32'h0,        64'h8,  4'h2, 32'h8,        1, g1));
        tbl.push_back(mk(0, 4'h2, 1, 32'h8,        64'h8,  4'h2, 32'h0,        1, g1));
        tbl.push_back(mk(0, 4'h0, 0, 32'h0,        64'h0,  4'h2, 32'h0,        0, g1));
        tbl.push_back(mk(0, 4'h0, 0, 32'h0,        64'h8,  4'h1, 32'h0,        0, g1));
        tbl.push_back(mk(0, 4'h0, 0, 32'h0,        64'h8,  4'h1, 32'h8,        0, g1));
        tbl.push_back(mk(0, 4'h2, 1, 32'h8,        64'h8,  4'h2, 32'h8,        0, g1));
        tbl.push_back(mk(0, 4'h0, 0, 32'h0,        64'h8,  4'h2, 32'h8,        1, g1));
        tbl.push_back(mk(0, 4'hC, 1, 32'hFFFFFFFF, 64'h8,  4'hC, 32'h0,        1, g1));
        tbl.push_back(mk(0, 4'hF, 0, 32'h0,        64'h8,  4'h3, 32'h8,        1, g1));
        tbl.push_back(mk(0, 4'h0, 1, 32'h1234,     64'h8,  4'h0, 32'h1234,     1, g2));
        tbl.push_back(mk(0, 4'h1, 1, 32'h0,        64'hFF, 4'h1, 32'h8,        1, g2));
        tbl.push_back(mk(0, 4'h0, 0, 32'h0,        64'hFF, 4'h1, 32'hFF,       1, g2));
        tbl.push_back(mk(0, 4'h0, 0, 32'h0,        64'hFF, 4'h2, 32'hFF,       1, g2));
        tbl.push_back(mk(1, 4'h0, 1, 32'h5555,     64'hFF, 4'h0, 32'h0,        0, 64'h0));
        tbl.push_back(mk(0, 4'h0, 0, 32'h0,        64'hFF, 4'h2, 32'h0,        0, 64'h0));
        tbl.push_back(mk(0, 4'h0, 0, 32'h0,        64'hFF, 4'h3, 32'h0,        0, 64'h0));
        tbl.push_back(mk(0, 4'h0, 0, 32'h0,        64'hFF, 4'h1, 32'hFF,       0, 64'h0));
        tbl.push_back(mk(0, 4'h0, 0, 32'h0,        64'hFF, 4'h4, 32'h0,        0, 64'h0));

        @(posedge clk); #1;
        foreach (tbl[i]) begin
            rst = tbl[i].rst; A = tbl[i].a; WE = tbl[i].we; WD = tbl[i].wd; gpI = tbl[i].pins;
            @(posedge clk); #1;
            rst = 1'b0; WE = 1'b0; A = tbl[i].ra;
            #1;
            erd = tbl[i].erd;
            if (!EIRQ && tbl[i].ra[1]) erd = '0;
            check($sformatf("row%0d_read", i), 64'(gpio_data_out), 64'(erd));
            check($sformatf("row%0d_irq",  i), 64'(irq), 64'(EIRQ & tbl[i].eirq));
            check($sformatf("row%0d_gpo",  i), gpO, tbl[i].egpo);
        end

        // ---------------- randomized phase ----------------
        rst = 1'b1; WE = 1'b0; gpI = '0;
        @(posedge clk); #1;
        model_step(1'b1, '0, 1'b0, '0, '0);
        rst = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            logic        r, we;
            logic [3:0]  a, ra;
            logic [31:0] wd;
            logic [63:0] pins;
            r    = ($urandom_range(0, 99) == 0);
            a    = 4'($urandom);
            we   = 1'($urandom_range(0, 1));
            wd   = $urandom;
            pins = gpI ^ ({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
            rst = r; A = a; WE = we; WD = wd; gpI = pins;
            @(posedge clk); #1;
            model_step(r, a, we, wd, pins);
            rst = 1'b0; WE = 1'b0;
            check($sformatf("rand%0d_gpo", n), gpO, exp_gpo());
            check($sformatf("rand%0d_irq", n), 64'(irq), 64'(EIRQ & m_irq));
            ra = 4'($urandom);
            A  = ra;
            #1;
            check($sformatf("rand%0d_read_a%h", n, ra), 64'(gpio_data_out), 64'(exp_read(ra)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/gpio_bank.md
GPIO_BANK -- requirements
Module: gpio_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 32: bits per channel, range 1..32.
REQ-002 SHALL have parameter NCH, default 2: number of channels, range 1..4.
REQ-003 SHALL have parameter SYNC_STAGES, default 2: input synchroniser depth, range 2..3.
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous reset, active-high.
REQ-006 SHALL have port A, input, 4: word address; A[3:2] selects the channel, A[1:0] selects the register.
REQ-007 SHALL have port WE, input, 1: write enable for the addressed register.
REQ-008 SHALL have port WD, input, WIDTH: write data.
REQ-009 SHALL have port gpI, input, NCH*WIDTH: asynchronous input pins; channel c occupies bits [c*WIDTH +: WIDTH].
REQ-010 SHALL have port gpO, output, NCH*WIDTH: output pins; channel c occupies bits [c*WIDTH +: WIDTH].
REQ-011 SHALL have port gpio_data_out, output, WIDTH: read data.
REQ-012 SHALL have port irq, output, 1: level interrupt.

Function
REQ-013 SHALL use this register map, selected by A[1:0]: 0 = OUT (read/write), 1 = IN (read-only), 2 = EDGE (write-1-to-clear), 3 = MASK (read/write).
REQ-014 SHALL drive gpO for channel c directly from OUT[c]; a write takes effect at the clk edge on which WE=1, with gpO visible the cycle after.
REQ-015 SHALL pass each gpI bit through a SYNC_STAGES-deep flop chain; IN[c] is the last stage of that chain, so a pin change appears in IN after SYNC_STAGES edges.
REQ-016 SHALL hold one additional delay flop per bit after the synchroniser; a rising edge is last stage = 1 while the delay flop = 0.
REQ-017 SHALL set EDGE[c][b] on the clk edge following the detected rising edge; the bit stays set until cleared.
REQ-018 SHALL, on a write to EDGE, clear every bit where WD = 1 and leave bits where WD = 0 unchanged.
REQ-019 SHALL keep an EDGE bit set when a set and a clear of that bit occur in the same cycle (set wins).
REQ-020 SHALL register irq as the OR over all channels of (EDGE[c] & MASK[c]), so irq follows EDGE/MASK changes by one cycle.
REQ-021 SHALL make gpio_data_out purely combinational from A and the current register contents, with zero-cycle read latency.
REQ-022 SHALL, when A[3:2] >= NCH, read 0 and ignore writes.
REQ-023 SHALL ignore writes to IN.
REQ-024 SHALL have no effect when WE=0.
REQ-025 SHALL let a write to one channel leave all other channels unchanged.
REQ-026 SHALL treat WD bits above WIDTH as non-existent; gpio_data_out has WIDTH bits only.

Reset
REQ-027 SHALL, when rst=1 at a clk edge, clear OUT, EDGE, MASK, all synchroniser and delay flops, and irq to 0.
REQ-028 SHALL keep gpO=0, gpio_data_out=0 for IN/EDGE/MASK/OUT reads, and irq=0 from the cycle after the reset edge.
REQ-029 SHALL give rst priority over a simultaneous WE.
REQ-030 SHALL detect no edge in the first cycle after reset for a pin that is held at 1 through reset; the delay flop is preloaded from the last stage on that first cycle.

Configuration
REQ-031 SHALL use macro GPIO_BANK_EDGE_IRQ_EN to include the edge/interrupt logic.
REQ-032 SHALL, when GPIO_BANK_EDGE_IRQ_EN is defined, implement EDGE, MASK, the delay flops and irq as specified above.
REQ-033 SHALL, when GPIO_BANK_EDGE_IRQ_EN is undefined, omit those flops, read 0 from EDGE and MASK, ignore writes to them, and tie irq to 0; OUT and IN behave identically in both builds.

Verification
REQ-034 SHALL cover: WIDTH=32, NCH=2; write OUT ch1 = 0xDEADBEEF -> gpO[63:32] = 0xDEADBEEF the next cycle, gpO[31:0] = 0, read A=4'b0100 returns 0xDEADBEEF.
REQ-035 SHALL cover: gpI[3] 0->1 at cycle t -> IN ch0 bit 3 = 1 at t+2, EDGE ch0 = 0x8 at t+3; with MASK ch0 = 0x8, irq = 1 at t+4.
REQ-036 SHALL cover: write EDGE ch0 with WD = 0x8 -> EDGE reads 0 and irq drops the next cycle; the same clear coinciding with a new bit-3 edge -> EDGE stays 0x8.
REQ-037 SHALL cover: NCH=2, write A=4'b1100 with WD = 0xFFFFFFFF -> no register changes and the read returns 0.
REQ-038 SHALL cover: rst pulsed while EDGE = 0xFF, OUT = 0x1234 and WE=1 -> all registers 0, irq = 0, and the write is dropped.
REQ-039 SHALL cover: build without GPIO_BANK_EDGE_IRQ_EN, toggle gpI -> EDGE/MASK read 0 and irq stays 0.
